vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between three requesters: the VGA scanout fetch, CPU writes and CPU reads.
- Sits between the pixel pipeline that drives red/green/blue/hsync/vsync and the VRAM instance inside top.
- Display fetch has absolute priority so scanout never stalls.
- CPU writes are absorbed by a small posted-write FIFO, and CPU reads are ordered after all earlier writes.

Parameters:
- ADDR_W, 15, VRAM word address width.
- DATA_W, 12, VRAM word width (4:4:4 RGB pixel).
- FIFO_DEPTH, 4, posted-write FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock; the block is fully synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- disp_req  in  1  display fetch request; single-cycle, may be asserted every cycle.
- disp_addr  in  ADDR_W  display fetch address, valid with disp_req.
- disp_data  out  DATA_W  fetched pixel word.
- disp_valid  out  1  one-cycle strobe qualifying disp_data.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  FIFO can accept a write.
- cpu_wr_addr  in  ADDR_W  CPU write address.
- cpu_wr_data  in  DATA_W  CPU write data.
- cpu_rd_req  in  1  CPU read request; level, held until cpu_rd_ack.
- cpu_rd_addr  in  ADDR_W  CPU read address, stable while cpu_rd_req is high.
- cpu_rd_data  out  DATA_W  CPU read result.
- cpu_rd_ack  out  1  one-cycle strobe qualifying cpu_rd_data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- mem_addr  out  ADDR_W  VRAM address (registered).
- mem_we  out  1  VRAM write enable (registered).
- mem_wdata  out  DATA_W  VRAM write data (registered).
- mem_rdata  in  DATA_W  VRAM read data, valid one cycle after the address is presented.

Behaviour:
- Reset (asynchronous): all of the following are 0.
  - disp_valid, disp_data, cpu_rd_ack, cpu_rd_data.
  - mem_addr, mem_we, mem_wdata, fifo_level.
  - FIFO pointers and the read FSM (which returns to IDLE).
- cpu_wr_ready = !full && !rst. It is combinational, with no pass-through while full.
- Push occurs when cpu_wr_valid && cpu_wr_ready.
- Grant priority each cycle, at most one grant:
  1. disp_req.
  2. FIFO non-empty: pop the head entry and issue a write.
  3. Read FSM in IDLE && cpu_rd_req && FIFO empty: issue the CPU read.
- No grant: mem_we <= 0, and mem_addr/mem_wdata hold their last value.
- Grant in cycle 0 registers mem_addr/mem_we/mem_wdata for cycle 1.
- Read pipeline timing:
  - The memory samples the address at the end of cycle 1.
  - mem_rdata is valid in cycle 2.
  - The block captures mem_rdata at the end of cycle 2.
  - The valid/ack strobe is high in cycle 3.
  - Read latency is therefore fixed at 3 cycles from request to strobe, fully pipelined.
- A 2-stage owner tag shift register travels with each read, encoded {none, disp, cpu}, and steers the captured data.
  - disp_data is updated only on disp reads.
  - cpu_rd_data is updated only on cpu reads; both hold otherwise.
- Read FSM:
  - IDLE -> BUSY on CPU read grant.
  - BUSY -> IDLE in the cycle cpu_rd_ack is high.
  - While in BUSY, no new CPU read is granted.
  - The requester drops cpu_rd_req in the cycle after the ack; a still-high req in the ack cycle is not re-granted.
- Ordering:
  - A CPU read is never granted while the FIFO is non-empty, so a read returns data from every write accepted before it.
  - Display reads are unordered with respect to CPU writes.
- Push and pop in the same cycle leave fifo_level unchanged.
- Full FIFO: cpu_wr_ready = 0, and pushes are ignored because the handshake is not satisfied.
- Starvation: continuous disp_req starves CPU traffic by design. Scanout only requests during active video, so CPU traffic drains in blanking.
- Reset mid-operation: in-flight reads are discarded with no strobes emitted after reset, and FIFO contents are lost.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, cpu_wr_ready = 1, fifo_level = 0.
- Preload VRAM[0x0010..0x0013] = 0x111..0x444; disp_req for 4 consecutive cycles at addrs 0x10..0x13 -> disp_valid high for 4 cycles starting 3 cycles after the first req, with data 0x111, 0x222, 0x333, 0x444 in order; cpu_rd_ack stays 0.
- Hold disp_req high continuously and push 5 CPU writes back-to-back -> 4 accepted, fifo_level = 4, cpu_wr_ready = 0 on the 5th, mem_we stays 0; drop disp_req -> 4 writes drain on consecutive cycles and cpu_wr_ready returns to 1 after the first pop.
- Write 0xABC to 0x0200, then immediately raise cpu_rd_req at 0x0200 -> the read is granted only after the FIFO empties, and cpu_rd_ack pulses once with cpu_rd_data = 0xABC.
- CPU read pending with disp_req pulsed in the same cycle -> the display read is granted first and the CPU read the next free cycle; both strobes appear with the correct owner and data 1 cycle apart.
- Assert rst while 2 reads are in flight and the FIFO holds 3 entries -> no disp_valid or cpu_rd_ack after reset, fifo_level = 0, mem_we = 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: display fetch, posted CPU writes and ordered CPU reads
// sharing one single-port synchronous-read video RAM.
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            disp_req,
    input  logic [ADDR_W-1:0]               disp_addr,
    output logic [DATA_W-1:0]               disp_data,
    output logic                            disp_valid,
    input  logic                            cpu_wr_valid,
    output logic                            cpu_wr_ready,
    input  logic [ADDR_W-1:0]               cpu_wr_addr,
    input  logic [DATA_W-1:0]               cpu_wr_data,
    input  logic                            cpu_rd_req,
    input  logic [ADDR_W-1:0]               cpu_rd_addr,
    output logic [DATA_W-1:0]               cpu_rd_data,
    output logic                            cpu_rd_ack,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            mem_we,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_t;
    typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              grant_rd;
    owner_t            tag1;
    owner_t            tag2;
    rd_state_t         rd_state;

    assign full         = (fifo_level == LW'(FIFO_DEPTH));
    assign empty        = (fifo_level == '0);
    assign cpu_wr_ready = !full && !rst;
    assign push         = cpu_wr_valid && cpu_wr_ready;
    assign pop          = !disp_req && !empty;
    // Reads wait for the FIFO to drain so they observe every earlier write.
    assign grant_rd     = !disp_req && empty && (rd_state == RD_IDLE) && cpu_rd_req;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr] <= cpu_wr_addr;
            fifo_data[wptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            fifo_level  <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            tag1        <= OWN_NONE;
            tag2        <= OWN_NONE;
            disp_valid  <= 1'b0;
            disp_data   <= '0;
            cpu_rd_ack  <= 1'b0;
            cpu_rd_data <= '0;
            rd_state    <= RD_IDLE;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase

            mem_we <= 1'b0;
            tag1   <= OWN_NONE;
            unique case (1'b1)
                disp_req: begin
                    mem_addr <= disp_addr;
                    tag1     <= OWN_DISP;
                end
                pop: begin
                    mem_addr  <= fifo_addr[rptr];
                    mem_wdata <= fifo_data[rptr];
                    mem_we    <= 1'b1;
                end
                grant_rd: begin
                    mem_addr <= cpu_rd_addr;
                    tag1     <= OWN_CPU;
                end
                default: ;
            endcase

            // tag2 lines up with mem_rdata being valid
            tag2       <= tag1;
            disp_valid <= (tag2 == OWN_DISP);
            cpu_rd_ack <= (tag2 == OWN_CPU);
            if (tag2 == OWN_DISP) disp_data   <= mem_rdata;
            if (tag2 == OWN_CPU)  cpu_rd_data <= mem_rdata;

            case (rd_state)
                RD_IDLE: if (grant_rd)   rd_state <= RD_BUSY;
                RD_BUSY: if (cpu_rd_ack) rd_state <= RD_IDLE;
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural
// synchronous-read VRAM attached to the memory port.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [14:0] disp_addr;
    logic [11:0] disp_data;
    logic        disp_valid;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [14:0] cpu_wr_addr;
    logic [11:0] cpu_wr_data;
    logic        cpu_rd_req;
    logic [14:0] cpu_rd_addr;
    logic [11:0] cpu_rd_data;
    logic        cpu_rd_ack;
    logic [2:0]  fifo_level;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    vram_arbiter dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_ack(cpu_rd_ack),
        .fifo_level(fifo_level),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [11:0] vram [0:32767];
    always @(posedge clk) begin
        if (mem_we) vram[mem_addr] <= mem_wdata;
        mem_rdata <= vram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] d;
        int          c;
    } exp_t;

    exp_t dq[$];
    exp_t cq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expected strobe data/cycle whenever the DUT strobes
    always @(negedge clk) begin
        if (!rst && disp_valid) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL disp_unexpected: data %0h cycle %0d", disp_data, cyc);
            end else begin
                exp_t e;
                e = dq.pop_front();
                if (disp_data !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL disp_read: got %0h@%0d expected %0h@%0d",
                             disp_data, cyc, e.d, e.c);
                end
            end
        end
        if (!rst && cpu_rd_ack) begin
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL cpu_unexpected: data %0h cycle %0d", cpu_rd_data, cyc);
            end else begin
                exp_t e;
                e = cq.pop_front();
                if (cpu_rd_data !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL cpu_read: got %0h@%0d expected %0h@%0d",
                             cpu_rd_data, cyc, e.d, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp_expect(input logic [11:0] d, input int lat);
        exp_t e;
        e.d = d;
        e.c = cyc + lat;
        dq.push_back(e);
    endtask

    // Holds the read request until the ack, drops it the cycle after
    task automatic cpu_read(input logic [14:0] a, input logic [11:0] d,
                            input int lat);
        exp_t e;
        bit   got;
        e.d = d;
        e.c = cyc + lat;
        cq.push_back(e);
        cpu_rd_req  = 1'b1;
        cpu_rd_addr = a;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            disp_req = 1'b0;
            if (cpu_rd_ack) got = 1'b1;
        end
        if (!got) begin
            errors++;
            $display("FAIL cpu_read_timeout: addr %0h", a);
        end
        tick();
        cpu_rd_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) vram[i] = '0;
        vram[15'h10] = 12'h111;
        vram[15'h11] = 12'h222;
        vram[15'h12] = 12'h333;
        vram[15'h13] = 12'h444;
        rst = 1'b1;
        disp_req = 0; disp_addr = 0;
        cpu_wr_valid = 0; cpu_wr_addr = 0; cpu_wr_data = 0;
        cpu_rd_req = 0; cpu_rd_addr = 0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_cpu_ack", cpu_rd_ack, 0);
        chk("rst_cpu_data", cpu_rd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_wr_ready", cpu_wr_ready, 1);

        // Display burst 0x10..0x13
        disp_req = 1'b1;
        disp_addr = 15'h10; disp_expect(12'h111, 3); tick();
        disp_addr = 15'h11; disp_expect(12'h222, 3); tick();
        disp_addr = 15'h12; disp_expect(12'h333, 3); tick();
        disp_addr = 15'h13; disp_expect(12'h444, 3); tick();
        disp_req = 1'b0;
        repeat (5) tick();
        chk("burst_drained", dq.size(), 0);

        // Writes under continuous display traffic
        disp_req  = 1'b1;
        disp_addr = 15'h10;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 15'h300 + 15'(i);
            cpu_wr_data  = 12'h5A0 + 12'(i);
            chk("wr_ready_fill", cpu_wr_ready, (i < 4) ? 1 : 0);
            chk("fill_mem_we", mem_we, 0);
            if (i == 4) chk("fill_level", fifo_level, 4);
            disp_expect(12'h111, 3);
            tick();
        end
        disp_req = 1'b0;
        cpu_wr_valid = 1'b0;
        chk("hold_mem_we", mem_we, 0);
        chk("hold_ready", cpu_wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_we", mem_we, 1);
            chk("drain_addr", mem_addr, 32'h300 + i);
            chk("drain_data", mem_wdata, 32'h5A0 + i);
            chk("drain_level", fifo_level, 3 - i);
            chk("drain_ready", cpu_wr_ready, 1);
        end
        tick();
        chk("drain_done_we", mem_we, 0);
        repeat (3) tick();
        chk("fill_disp_drained", dq.size(), 0);

        // Read-after-write ordering
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 15'h200;
        cpu_wr_data  = 12'hABC;
        tick();
        cpu_wr_valid = 1'b0;
        cpu_read(15'h200, 12'hABC, 4);
        cpu_read(15'h303, 12'h5A3, 3);
        cpu_read(15'h304, 12'h000, 3);

        // Display and CPU read requested together
        disp_req  = 1'b1;
        disp_addr = 15'h11;
        disp_expect(12'h222, 3);
        cpu_read(15'h12, 12'h333, 4);
        repeat (3) tick();
        chk("mixed_disp_drained", dq.size(), 0);
        chk("mixed_cpu_drained", cq.size(), 0);

        // Reset with reads in flight and a partly full FIFO
        cpu_wr_valid = 1'b1;
        cpu_wr_addr = 15'h400; cpu_wr_data = 12'h001; tick();
        disp_req = 1'b1; disp_addr = 15'h10;
        cpu_wr_addr = 15'h401; cpu_wr_data = 12'h002; tick();
        disp_addr = 15'h11;
        cpu_wr_addr = 15'h402; cpu_wr_data = 12'h003; tick();
        disp_req = 1'b0;
        cpu_wr_valid = 1'b0;
        chk("pre_rst_level", fifo_level, 3);
        rst = 1'b1;
        #1;
        chk("async_rst_level", fifo_level, 0);
        chk("async_rst_we", mem_we, 0);
        chk("async_rst_ready", cpu_wr_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_disp_valid", disp_valid, 0);
            chk("post_rst_cpu_ack", cpu_rd_ack, 0);
            chk("post_rst_we", mem_we, 0);
            tick();
        end
        chk("post_rst_level", fifo_level, 0);
        chk("post_rst_ready", cpu_wr_ready, 1);
        chk("lost_write", vram[15'h400], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
